llc_pending_table: RTL and testbench

// - Parametrised tracker for in-flight LLC transactions (recall, DMA read, DMA write, stalled req).
// - Generalises the single-bit pending/stall registers to NUM_ENTRIES outstanding entries.
// - Provides same-cycle set/line conflict lookup for the request decoder and a per-set sweep

---
 rtl/llc_pending_table_if.sv | 47 ++++
 rtl/llc_pending_table.sv | 124 ++++++++++++
 tb/tb_llc_pending_table.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/llc_pending_table_if.sv
// llc_pending_table_if: alloc/release/lookup/status/sweep bundle for llc_pending_table
interface llc_pending_table_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int SET_BITS    = 9,
  parameter int TAG_BITS    = 16,
  parameter int KINDS       = 4
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int KW = $clog2(KINDS);
  localparam int CW = $clog2(NUM_ENTRIES + 1);
  logic                clr;
  logic                alloc_valid;
  logic                alloc_ready;
  logic [SET_BITS-1:0] alloc_set;
  logic [TAG_BITS-1:0] alloc_tag;
  logic [KW-1:0]       alloc_kind;
  logic [IW-1:0]       alloc_id;
  logic                release_valid;
  logic [IW-1:0]       release_id;
  logic [SET_BITS-1:0] lookup_set;
  logic [TAG_BITS-1:0] lookup_tag;
  logic                lookup_set_hit;
  logic                lookup_line_hit;
  logic [IW-1:0]       lookup_hit_id;
  logic [KINDS-1:0]    kind_pending;
  logic [CW-1:0]       occupancy;
  logic                full;
  logic                empty;
  logic                release_err;
  logic                sweep_start;
  logic                sweep_incr;
  logic [SET_BITS-1:0] sweep_set;
  logic                sweep_active;
  logic                sweep_done;
  modport master (
    output clr, alloc_valid, alloc_set, alloc_tag, alloc_kind, release_valid, release_id,
           lookup_set, lookup_tag, sweep_start, sweep_incr,
    input  alloc_ready, alloc_id, lookup_set_hit, lookup_line_hit, lookup_hit_id, kind_pending,
           occupancy, full, empty, release_err, sweep_set, sweep_active, sweep_done
  );
  modport slave (
    input  clr, alloc_valid, alloc_set, alloc_tag, alloc_kind, release_valid, release_id,
           lookup_set, lookup_tag, sweep_start, sweep_incr,
    output alloc_ready, alloc_id, lookup_set_hit, lookup_line_hit, lookup_hit_id, kind_pending,
           occupancy, full, empty, release_err, sweep_set, sweep_active, sweep_done
  );
endinterface

// File: rtl/llc_pending_table.sv
// llc_pending_table: tracks in-flight LLC transactions with set/line lookup and a set sweep walker
module llc_pending_table #(
  parameter int NUM_ENTRIES = 4,
  parameter int SET_BITS    = 9,
  parameter int TAG_BITS    = 16,
  parameter int KINDS       = 4
) (
  input logic clk,
  input logic rst,
  llc_pending_table_if.slave bus
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int KW = $clog2(KINDS);
  localparam int CW = $clog2(NUM_ENTRIES + 1);
  typedef enum logic {IDLE, WALK} state_t;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [SET_BITS-1:0]    set_q [NUM_ENTRIES];
  logic [SET_BITS-1:0]    set_d [NUM_ENTRIES];
  logic [TAG_BITS-1:0]    tag_q [NUM_ENTRIES];
  logic [TAG_BITS-1:0]    tag_d [NUM_ENTRIES];
  logic [KW-1:0]          kind_q [NUM_ENTRIES];
  logic [KW-1:0]          kind_d [NUM_ENTRIES];
  logic                   err_q, err_d;
  state_t                 state_q, state_d;
  logic [SET_BITS-1:0]    sweep_set_q, sweep_set_d;
  logic                   done_q, done_d;
  logic [IW-1:0]          alloc_id, hit_id;
  logic [CW-1:0]          occ;
  logic [KINDS-1:0]       kp;
  logic                   set_hit, line_hit, full, fire;
  // Everything below reads only the registered table, so same-cycle allocs stay invisible
  always_comb begin
    alloc_id = '0;
    hit_id = '0;
    occ = '0;
    kp = '0;
    set_hit = 1'b0;
    line_hit = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      alloc_id = valid_q[i] ? alloc_id : IW'(i);
      hit_id = (valid_q[i] && set_q[i] == bus.lookup_set) ? IW'(i) : hit_id;
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      occ = occ + CW'(valid_q[i]);
      kp[kind_q[i]] = kp[kind_q[i]] | valid_q[i];
      set_hit = set_hit | (valid_q[i] && set_q[i] == bus.lookup_set);
      line_hit = line_hit | (valid_q[i] && set_q[i] == bus.lookup_set && tag_q[i] == bus.lookup_tag);
    end
  end
  assign full = occ == CW'(NUM_ENTRIES);
  assign fire = bus.alloc_valid && !full;
  // alloc_id is always a free slot, so it never collides with a valid release target
  always_comb begin
    valid_d = valid_q;
    set_d = set_q;
    tag_d = tag_q;
    kind_d = kind_q;
    err_d = err_q;
    if (bus.release_valid) begin
      valid_d[bus.release_id] = 1'b0;
      err_d = err_q | !valid_q[bus.release_id];
    end
    if (fire) begin
      valid_d[alloc_id] = 1'b1;
      set_d[alloc_id] = bus.alloc_set;
      tag_d[alloc_id] = bus.alloc_tag;
      kind_d[alloc_id] = bus.alloc_kind;
    end
    if (bus.clr) begin
      valid_d = '0;
      err_d = 1'b0;
    end
  end
  always_comb begin
    state_d = state_q;
    sweep_set_d = sweep_set_q;
    done_d = 1'b0;
    if (bus.sweep_start) begin
      state_d = WALK;
      sweep_set_d = '0;
    end else if (state_q == WALK && bus.sweep_incr) begin
      sweep_set_d = sweep_set_q + 1'b1;
      state_d = &sweep_set_q ? IDLE : WALK;
      done_d = &sweep_set_q;
    end
    if (bus.clr) begin
      state_d = IDLE;
      sweep_set_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      err_q <= 1'b0;
      state_q <= IDLE;
      sweep_set_q <= '0;
      done_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      err_q <= err_d;
      state_q <= state_d;
      sweep_set_q <= sweep_set_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    set_q <= set_d;
    tag_q <= tag_d;
    kind_q <= kind_d;
  end
  assign bus.alloc_ready = !full;
  assign bus.alloc_id = alloc_id;
  assign bus.lookup_set_hit = set_hit;
  assign bus.lookup_line_hit = line_hit;
  assign bus.lookup_hit_id = hit_id;
  assign bus.kind_pending = kp;
  assign bus.occupancy = occ;
  assign bus.full = full;
  assign bus.empty = occ == '0;
  assign bus.release_err = err_q;
  assign bus.sweep_set = sweep_set_q;
  assign bus.sweep_active = state_q == WALK;
  assign bus.sweep_done = done_q;
endmodule

// File: tb/tb_llc_pending_table.sv
// tb_llc_pending_table: directed checks of the entry table (default sizing) and sweep walker (SET_BITS=2)
module tb_llc_pending_table;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  llc_pending_table_if b0 ();
  llc_pending_table_if #(.SET_BITS(2)) b1 ();
  llc_pending_table u0 (.clk(clk), .rst(rst), .bus(b0));
  llc_pending_table #(.SET_BITS(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic alloc(input logic [8:0] s, input logic [15:0] t, input logic [1:0] k);
    b0.alloc_valid = 1'b1;
    b0.alloc_set = s;
    b0.alloc_tag = t;
    b0.alloc_kind = k;
  endtask
  initial begin
    {b0.clr, b0.alloc_valid, b0.alloc_set, b0.alloc_tag, b0.alloc_kind, b0.release_valid,
     b0.release_id, b0.lookup_set, b0.lookup_tag, b0.sweep_start, b0.sweep_incr} = '0;
    {b1.clr, b1.alloc_valid, b1.alloc_set, b1.alloc_tag, b1.alloc_kind, b1.release_valid,
     b1.release_id, b1.lookup_set, b1.lookup_tag, b1.sweep_start, b1.sweep_incr} = '0;
    #12 rst = 1'b0;
    step();
    check("rst_empty", b0.empty, 1);
    check("rst_occ", b0.occupancy, 0);
    check("rst_alloc_id", b0.alloc_id, 0);
    check("rst_kind", b0.kind_pending, 0);
    check("rst_full", b0.full, 0);
    check("rst_err", b0.release_err, 0);
    check("rst_sweep_active", b1.sweep_active, 0);
    alloc(9'd5, 16'h1A, 2'd1);
    #1 check("a0_id", b0.alloc_id, 0);
    check("a0_ready", b0.alloc_ready, 1);
    step();
    check("a0_occ", b0.occupancy, 1);
    check("a0_empty", b0.empty, 0);
    check("a1_id", b0.alloc_id, 1);
    alloc(9'd5, 16'h2B, 2'd3);
    step();
    check("a2_id", b0.alloc_id, 2);
    alloc(9'd7, 16'h33, 2'd0);
    step();
    check("a3_id", b0.alloc_id, 3);
    alloc(9'd9, 16'h44, 2'd2);
    step();
    check("full", b0.full, 1);
    check("ready_full", b0.alloc_ready, 0);
    check("kind_all", b0.kind_pending, 4'hF);
    check("occ4", b0.occupancy, 4);
    alloc(9'd6, 16'h55, 2'd1);
    b0.lookup_set = 9'd5;
    b0.lookup_tag = 16'h2B;
    #1 check("lk5_set", b0.lookup_set_hit, 1);
    check("lk5_line", b0.lookup_line_hit, 1);
    check("lk5_id", b0.lookup_hit_id, 0);
    b0.lookup_set = 9'd7;
    #1 check("lk7_id", b0.lookup_hit_id, 2);
    step();
    b0.lookup_set = 9'd6;
    #1 check("alloc5_occ", b0.occupancy, 4);
    check("lk6_set", b0.lookup_set_hit, 0);
    check("lk6_line", b0.lookup_line_hit, 0);
    b0.release_valid = 1'b1;
    b0.release_id = 2'd1;
    step();
    b0.alloc_valid = 1'b0;
    b0.release_valid = 1'b0;
    b0.lookup_set = 9'd5;
    #1 check("rel_alloc_occ", b0.occupancy, 3);
    check("rel_full", b0.full, 0);
    check("rel_alloc_id", b0.alloc_id, 1);
    check("rel_kind", b0.kind_pending, 4'h7);
    check("rel_lk_set", b0.lookup_set_hit, 1);
    check("rel_lk_line", b0.lookup_line_hit, 0);
    check("err_clean", b0.release_err, 0);
    b0.release_valid = 1'b1;
    b0.release_id = 2'd1;
    step();
    b0.release_valid = 1'b0;
    check("err_set", b0.release_err, 1);
    check("err_occ", b0.occupancy, 3);
    step();
    check("err_sticky", b0.release_err, 1);
    alloc(9'd8, 16'h3, 2'd3);
    b0.release_valid = 1'b1;
    b0.release_id = 2'd0;
    step();
    b0.alloc_valid = 1'b0;
    b0.release_valid = 1'b0;
    check("swap_occ", b0.occupancy, 3);
    check("swap_alloc_id", b0.alloc_id, 0);
    check("swap_kind", b0.kind_pending, 4'hD);
    b0.lookup_set = 9'd8;
    b0.lookup_tag = 16'h3;
    #1 check("swap_lk_id", b0.lookup_hit_id, 1);
    check("swap_lk_line", b0.lookup_line_hit, 1);
    b0.clr = 1'b1;
    alloc(9'd4, 16'h9, 2'd0);
    step();
    b0.clr = 1'b0;
    b0.alloc_valid = 1'b0;
    check("clr_occ", b0.occupancy, 0);
    check("clr_empty", b0.empty, 1);
    check("clr_err", b0.release_err, 0);
    check("clr_kind", b0.kind_pending, 0);
    b1.sweep_incr = 1'b1;
    step();
    check("idle_incr", b1.sweep_set, 0);
    b1.sweep_incr = 1'b0;
    b1.sweep_start = 1'b1;
    step();
    b1.sweep_start = 1'b0;
    check("sw_start_active", b1.sweep_active, 1);
    check("sw_s0", b1.sweep_set, 0);
    b1.sweep_incr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("sw_walk", b1.sweep_set, i);
      check("sw_walk_done", b1.sweep_done, 0);
    end
    step();
    check("sw_wrap", b1.sweep_set, 0);
    check("sw_done", b1.sweep_done, 1);
    check("sw_idle", b1.sweep_active, 0);
    step();
    check("sw_done_pulse", b1.sweep_done, 0);
    check("sw_idle_hold", b1.sweep_set, 0);
    b1.sweep_incr = 1'b0;
    b1.sweep_start = 1'b1;
    step();
    b1.sweep_start = 1'b0;
    b1.sweep_incr = 1'b1;
    step();
    step();
    check("sw_pre_restart", b1.sweep_set, 2);
    b1.sweep_start = 1'b1;
    step();
    b1.sweep_start = 1'b0;
    check("sw_restart", b1.sweep_set, 0);
    check("sw_restart_active", b1.sweep_active, 1);
    step();
    b1.sweep_incr = 1'b0;
    check("sw_mid", b1.sweep_set, 1);
    #2 rst = 1'b1;
    #1 check("rst_mid_active", b1.sweep_active, 0);
    check("rst_mid_set", b1.sweep_set, 0);
    #4 rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
